// File: rtl/tpu_cfg_master_pkg.sv
// Shared constants for the TPU configuration master:
// register map, CTRL bit layout, write count and FSM states.
package tpu_cfg_master_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_TX_SLOT = 8'h01;
  localparam logic [7:0] ADDR_RX_SLOT = 8'h02;
  localparam logic [7:0] ADDR_TMR_LO  = 8'h03;
  localparam logic [7:0] ADDR_TMR_HI  = 8'h04;

  localparam int CTRL_RSTTPU      = 0;
  localparam int CTRL_TIMERINTMSK = 1;
  localparam int CTRL_INTFLAG     = 2;
  localparam int CTRL_TXSLOT_EN   = 3;
  localparam int CTRL_RXSLOT_EN   = 4;

  localparam int NUM_CFG_WRITES = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } cfg_state_t;

  // CTRL byte; INTFLAG is always written as 0
  function automatic logic [7:0] ctrl_byte(
    input logic rxen,
    input logic txen,
    input logic msk,
    input logic rst
  );
    logic [7:0] b;
    b = '0;
    b[CTRL_RSTTPU]      = rst;
    b[CTRL_TIMERINTMSK] = msk;
    b[CTRL_INTFLAG]     = 1'b0;
    b[CTRL_TXSLOT_EN]   = txen;
    b[CTRL_RXSLOT_EN]   = rxen;
    return b;
  endfunction

endpackage

// File: rtl/tpu_cfg_master.sv
// TPU config master: latches a configuration on cfg_start and
// issues six byte writes (addr_out/data_out, valid/ready handshake).
// Ports: SYS_CLK, SYS_RST (sync, active high); cfg_* config inputs;
//   addr_out/data_out/valid_out_m/ready_out write channel;
//   busy (sequence active), done (1-cycle pulse), err (sticky timeout).
module tpu_cfg_master
  import tpu_cfg_master_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        SYS_CLK,
  input  logic        SYS_RST,
  input  logic        cfg_start,
  input  logic        cfg_timer_int_msk,
  input  logic        cfg_txslot_en,
  input  logic        cfg_rxslot_en,
  input  logic [7:0]  cfg_tx_slot,
  input  logic [7:0]  cfg_rx_slot,
  input  logic [15:0] cfg_timer_value,
  output logic [7:0]  addr_out,
  output logic [7:0]  data_out,
  output logic        valid_out_m,
  input  logic        ready_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_CFG_WRITES - 1);

  cfg_state_t    r_state;
  logic [2:0]    r_idx;
  logic [TW-1:0] r_tmo;

  logic          r_msk;
  logic          r_txen;
  logic          r_rxen;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic [15:0]   r_tmr;

  logic [2:0]    w_nidx;
  logic [7:0]    w_naddr;
  logic [7:0]    w_ndata;

  assign w_nidx = r_idx + 3'd1;

  // Next write in the table, built from the shadow copy.
  // Index 0 is loaded straight from the inputs at start.
  always_comb begin
    w_naddr = ADDR_CTRL;
    w_ndata = ctrl_byte(r_rxen, r_txen, r_msk, 1'b1);
    unique case (w_nidx)
      3'd1: begin
        w_naddr = ADDR_TX_SLOT;
        w_ndata = r_tx;
      end
      3'd2: begin
        w_naddr = ADDR_RX_SLOT;
        w_ndata = r_rx;
      end
      3'd3: begin
        w_naddr = ADDR_TMR_LO;
        w_ndata = r_tmr[7:0];
      end
      3'd4: begin
        w_naddr = ADDR_TMR_HI;
        w_ndata = r_tmr[15:8];
      end
      3'd5: begin
        w_naddr = ADDR_CTRL;
        w_ndata = ctrl_byte(r_rxen, r_txen, r_msk, 1'b0);
      end
      default: begin
        w_naddr = ADDR_CTRL;
        w_ndata = ctrl_byte(r_rxen, r_txen, r_msk, 1'b1);
      end
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_msk       <= 1'b0;
      r_txen      <= 1'b0;
      r_rxen      <= 1'b0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_tmr       <= '0;
      addr_out    <= '0;
      data_out    <= '0;
      valid_out_m <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cfg_start) begin
            r_msk       <= cfg_timer_int_msk;
            r_txen      <= cfg_txslot_en;
            r_rxen      <= cfg_rxslot_en;
            r_tx        <= cfg_tx_slot;
            r_rx        <= cfg_rx_slot;
            r_tmr       <= cfg_timer_value;
            r_idx       <= '0;
            r_tmo       <= '0;
            err         <= 1'b0;
            valid_out_m <= 1'b1;
            busy        <= 1'b1;
            addr_out    <= ADDR_CTRL;
            data_out    <= ctrl_byte(cfg_rxslot_en,
                                     cfg_txslot_en,
                                     cfg_timer_int_msk,
                                     1'b1);
            r_state     <= XFER;
          end
        end
        XFER: begin
          if (ready_out) begin
            if (r_idx == LAST_IDX) begin
              valid_out_m <= 1'b0;
              done        <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_idx    <= w_nidx;
              r_tmo    <= '0;
              addr_out <= w_naddr;
              data_out <= w_ndata;
            end
          end else if (r_tmo == TMO_LAST) begin
            valid_out_m <= 1'b0;
            err         <= 1'b1;
            r_state     <= ERR;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        ERR: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
